// File: rtl/ga_grade_analyzer.sv
// Multi-cycle grade analyzer: scans a multivector LanesPerCycle blades per beat and reports
// per-grade occupancy above a noise floor, the dominant grade and its peak magnitude.
module ga_grade_analyzer #(
  parameter int unsigned MvWidth       = 16,
  parameter int unsigned NumBlades     = 32,
  parameter int unsigned LanesPerCycle = 4,
  localparam int unsigned Dim          = $clog2(NumBlades),
  localparam int unsigned NumGrades    = Dim + 1,
  localparam int unsigned GradeW       = $clog2(NumGrades)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NumBlades*MvWidth-1:0] mv_i,
  input  logic [MvWidth-1:0]           threshold_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NumGrades-1:0]         grade_mask_o,
  output logic [GradeW-1:0]            dominant_grade_o,
  output logic [MvWidth-1:0]           dominant_mag_o,
  output logic                         is_zero_o,
  output logic                         is_homogeneous_o,
  output logic                         busy_o
);

  localparam int unsigned NumBeats = NumBlades / LanesPerCycle;
  localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                      state_q, state_d;
  logic [BeatW-1:0]            beat_q;
  logic [NumBlades*MvWidth-1:0] mv_q;
  logic [MvWidth-1:0]          thr_q;
  logic [MvWidth-1:0]          maxmag_q [NumGrades];
  logic [MvWidth-1:0]          maxmag_d [NumGrades];
  logic [NumGrades-1:0]        mask_q, mask_d;
  logic [GradeW-1:0]           best_grade;
  logic [MvWidth-1:0]          best_mag;
  logic                        last_beat;

  logic [NumGrades-1:0]        res_mask_q;
  logic [GradeW-1:0]           res_grade_q;
  logic [MvWidth-1:0]          res_mag_q;
  logic                        res_zero_q, res_homog_q;

  function automatic logic [GradeW-1:0] popcount(input logic [Dim-1:0] v);
    logic [GradeW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(Dim); i++) c = c + GradeW'(v[i]);
    return c;
  endfunction

  assign last_beat = (beat_q == BeatW'(NumBeats - 1));

  // Lanes fold into the accumulators in order, so same-grade lanes in one beat all count.
  always_comb begin
    maxmag_d = maxmag_q;
    mask_d   = mask_q;
    for (int l = 0; l < int'(LanesPerCycle); l++) begin
      int unsigned       idx;
      logic [MvWidth-1:0] coeff;
      logic [MvWidth-1:0] mag;
      logic [GradeW-1:0]  g;
      idx   = int'(beat_q) * LanesPerCycle + l;
      coeff = mv_q[idx*MvWidth +: MvWidth];
      mag   = coeff[MvWidth-1] ? (~coeff + 1'b1) : coeff;
      g     = popcount(idx[Dim-1:0]);
      if (mag > maxmag_d[g]) maxmag_d[g] = mag;
      if (mag > thr_q) mask_d[g] = 1'b1;
    end
    // Strict compare keeps the lowest grade on ties.
    best_grade = '0;
    best_mag   = maxmag_d[0];
    for (int g = 1; g < int'(NumGrades); g++) begin
      if (maxmag_d[g] > best_mag) begin
        best_mag   = maxmag_d[g];
        best_grade = GradeW'(g);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid_i) state_d = StScan;
      StScan: if (last_beat) state_d = StDone;
      StDone: if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (clear_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      mv_q        <= '0;
      thr_q       <= '0;
      maxmag_q    <= '{default: '0};
      mask_q      <= '0;
      res_mask_q  <= '0;
      res_grade_q <= '0;
      res_mag_q   <= '0;
      res_zero_q  <= 1'b1;
      res_homog_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        beat_q      <= '0;
        res_mask_q  <= '0;
        res_grade_q <= '0;
        res_mag_q   <= '0;
        res_zero_q  <= 1'b1;
        res_homog_q <= 1'b0;
      end else if (state_q == StIdle) begin
        if (in_valid_i) begin
          mv_q     <= mv_i;
          thr_q    <= threshold_i;
          maxmag_q <= '{default: '0};
          mask_q   <= '0;
          beat_q   <= '0;
        end
      end else if (state_q == StScan) begin
        maxmag_q <= maxmag_d;
        mask_q   <= mask_d;
        beat_q   <= beat_q + 1'b1;
        if (last_beat) begin
          res_mask_q  <= mask_d;
          res_grade_q <= best_grade;
          res_mag_q   <= best_mag;
          res_zero_q  <= (mask_d == '0);
          res_homog_q <= $onehot(mask_d);
        end
      end
    end
  end

  assign in_ready_o       = (state_q == StIdle);
  assign busy_o           = (state_q != StIdle);
  assign out_valid_o      = (state_q == StDone);
  assign grade_mask_o     = res_mask_q;
  assign dominant_grade_o = res_grade_q;
  assign dominant_mag_o   = res_mag_q;
  assign is_zero_o        = res_zero_q;
  assign is_homogeneous_o = res_homog_q;

endmodule

// File: tb/tb_ga_grade_analyzer.sv
// Directed bench for ga_grade_analyzer with hand-computed expectations.
module tb_ga_grade_analyzer;
  localparam int W  = 16;
  localparam int NB = 32;
  localparam int NG = 6;

  logic              clk_i = 1'b0;
  logic              rst_ni, clear_i, in_valid_i, out_ready_i;
  logic [NB*W-1:0]   mv_i;
  logic [W-1:0]      threshold_i;
  logic              in_ready_o, out_valid_o, is_zero_o, is_homogeneous_o, busy_o;
  logic [NG-1:0]     grade_mask_o;
  logic [2:0]        dominant_grade_o;
  logic [W-1:0]      dominant_mag_o;

  int n_checks = 0;
  int n_pass   = 0;

  ga_grade_analyzer #(.MvWidth(W), .NumBlades(NB), .LanesPerCycle(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .mv_i            (mv_i),
    .threshold_i     (threshold_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .grade_mask_o    (grade_mask_o),
    .dominant_grade_o(dominant_grade_o),
    .dominant_mag_o  (dominant_mag_o),
    .is_zero_o       (is_zero_o),
    .is_homogeneous_o(is_homogeneous_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NB*W-1:0] put(input logic [NB*W-1:0] m, input int i,
                                          input logic [W-1:0] v);
    m[i*W +: W] = v;
    return m;
  endfunction

  // Accept edge counts as latency 1; returns with outputs sampled #1 after the valid edge.
  task automatic send(input logic [NB*W-1:0] m, input logic [W-1:0] t, output int lat);
    @(negedge clk_i);
    mv_i = m; threshold_i = t; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk_i); out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic check_res(input string tag, input int lat, input logic [NG-1:0] mask,
                           input logic [2:0] dom, input logic [W-1:0] mag,
                           input logic zero, input logic homog);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_valid"}, out_valid_o, 1);
    check({tag, "_mask"}, grade_mask_o, mask);
    check({tag, "_dom"}, dominant_grade_o, dom);
    check({tag, "_mag"}, dominant_mag_o, mag);
    check({tag, "_zero"}, is_zero_o, zero);
    check({tag, "_homog"}, is_homogeneous_o, homog);
  endtask

  initial begin
    logic [NB*W-1:0] m, m2;
    int lat;
    logic stable, seen;
    logic [NG-1:0] s_mask;
    logic [2:0] s_dom;
    logic [W-1:0] s_mag;

    rst_ni = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    mv_i = '0; threshold_i = '0;
    #12 rst_ni = 1'b1;
    #1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_mask", grade_mask_o, 0);
    check("rst_dom", dominant_grade_o, 0);
    check("rst_mag", dominant_mag_o, 0);
    check("rst_zero", is_zero_o, 1);
    check("rst_homog", is_homogeneous_o, 0);

    m = put('0, 0, 16'd5);
    send(m, 16'd0, lat);
    check_res("scalar", lat, 6'b000001, 3'd0, 16'd5, 1'b0, 1'b1);
    check("scalar_in_ready", in_ready_o, 0);
    consume();

    m = put('0, 3, 16'h8000);
    send(m, 16'd0, lat);
    check_res("extreme", lat, 6'b000100, 3'd2, 16'h8000, 1'b0, 1'b1);
    consume();

    m = put('0, 1, 16'hFFF9);
    m = put(m, 6, 16'd7);
    m = put(m, 31, 16'd2);
    send(m, 16'd0, lat);
    check_res("tie", lat, 6'b100110, 3'd1, 16'd7, 1'b0, 1'b0);
    consume();

    // Same-grade lanes in one beat; the larger one sits in the earlier lane.
    m = put('0, 12, 16'h0050);
    m = put(m, 13, 16'h0090);
    m = put(m, 14, 16'hFFA0);
    m = put(m, 15, 16'h0010);
    send(m, 16'd0, lat);
    check_res("lanes", lat, 6'b011100, 3'd3, 16'h0090, 1'b0, 1'b0);
    consume();

    m = put('0, 1, 16'd3);
    send(m, 16'd3, lat);
    check_res("thr3", lat, 6'b000000, 3'd1, 16'd3, 1'b1, 1'b0);
    consume();
    send(m, 16'd2, lat);
    check_res("thr2", lat, 6'b000010, 3'd1, 16'd3, 1'b0, 1'b1);
    consume();

    // Backpressure with a second request held by the producer.
    m  = put('0, 31, 16'hFFFF);
    m2 = put('0, 5, 16'h0100);
    send(m, 16'd0, lat);
    check_res("bp1", lat, 6'b100000, 3'd5, 16'd1, 1'b0, 1'b1);
    s_mask = grade_mask_o; s_dom = dominant_grade_o; s_mag = dominant_mag_o;
    @(negedge clk_i);
    mv_i = m2; threshold_i = '0; in_valid_i = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (!out_valid_o || in_ready_o || grade_mask_o != s_mask || dominant_grade_o != s_dom ||
          dominant_mag_o != s_mag) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    @(negedge clk_i); out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    check("bp_release_valid", out_valid_o, 0);
    check("bp_release_ready", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    check("bp2_busy", busy_o, 1);
    lat = 1;
    while (!out_valid_o && lat < 40) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check_res("bp2", lat, 6'b000100, 3'd2, 16'h0100, 1'b0, 1'b1);
    consume();

    // Abort mid-scan at beat 4.
    @(negedge clk_i);
    mv_i = put('0, 0, 16'd5); threshold_i = '0; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i); clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    check("clr_busy", busy_o, 0);
    check("clr_in_ready", in_ready_o, 1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen = 1'b1;
    end
    check("clr_no_valid", seen, 0);

    // clear_i blocks a simultaneous accept.
    @(negedge clk_i); clear_i = 1'b1; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; in_valid_i = 1'b0;
    check("clr_no_accept", busy_o, 0);

    // Asynchronous reset while in DONE.
    send(put('0, 2, 16'd9), 16'd0, lat);
    check("pre_rst_valid", out_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_in_ready", in_ready_o, 1);
    check("arst_busy", busy_o, 0);
    check("arst_mask", grade_mask_o, 0);
    check("arst_dom", dominant_grade_o, 0);
    check("arst_mag", dominant_mag_o, 0);
    check("arst_zero", is_zero_o, 1);
    check("arst_homog", is_homogeneous_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    send(put('0, 0, 16'd5), 16'd0, lat);
    check_res("post_rst", lat, 6'b000001, 3'd0, 16'd5, 1'b0, 1'b1);
    consume();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
